// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM/WB pipeline register and write-back datapath. Captures the
//            MEM-stage result, extracts and extends load bytes/halfwords,
//            drives the register-file write port and keeps a
//            retired-instruction counter.
// Ports    : clk, rst (async, active-high)
//            stall / flush           - hold / bubble control
//            *_mem                   - MEM-stage instruction fields
//            valid_wb, RegWrite_wb   - WB instruction valid / write enable
//            RegWriteAddr_wb/Data_wb - register-file write address / data
//            RetireCount             - retired-instruction counter
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_mem,
  input  logic                 RegWrite_mem,
  input  logic                 MemToReg_mem,
  input  logic [2:0]           LoadType_mem,
  input  logic [4:0]           RegWriteAddr_mem,
  input  logic [31:0]          AluResult_mem,
  input  logic [31:0]          MemReadData_mem,
  output logic                 valid_wb,
  output logic                 RegWrite_wb,
  output logic [4:0]           RegWriteAddr_wb,
  output logic [31:0]          RegWriteData_wb,
  output logic [CNT_WIDTH-1:0] RetireCount
);

  localparam logic [2:0] C_LT_LB  = 3'b001;
  localparam logic [2:0] C_LT_LBU = 3'b010;
  localparam logic [2:0] C_LT_LH  = 3'b011;
  localparam logic [2:0] C_LT_LHU = 3'b100;

  logic                 r_valid;
  logic                 r_regwrite;
  logic                 r_memtoreg;
  logic [2:0]           r_loadtype;
  logic [4:0]           r_addr;
  logic [31:0]          r_alu;
  logic [31:0]          r_rdata;
  logic [CNT_WIDTH-1:0] r_retire;

  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_load;
  logic [31:0]          w_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_loadtype <= 3'b000;
      r_addr     <= 5'd0;
      r_alu      <= 32'd0;
      r_rdata    <= 32'd0;
      r_retire   <= '0;
    end else begin
      // Flush beats stall; the remaining fields are irrelevant in a bubble,
      // so they simply hold.
      if (flush) begin
        r_valid    <= 1'b0;
        r_regwrite <= 1'b0;
      end else if (!stall) begin
        r_valid    <= valid_mem;
        r_regwrite <= RegWrite_mem;
        r_memtoreg <= MemToReg_mem;
        r_loadtype <= LoadType_mem;
        r_addr     <= RegWriteAddr_mem;
        r_alu      <= AluResult_mem;
        r_rdata    <= MemReadData_mem;
      end
      // The outgoing instruction retires even when a flush replaces it.
      if (r_valid && !stall) begin
        r_retire <= r_retire + CNT_WIDTH'(1);
      end
    end
  end

  // Little-endian lane selection; AluResult[0] is ignored for halfwords.
  always_comb begin
    w_byte = 8'd0;
    case (r_alu[1:0])
      2'd0:    w_byte = r_rdata[7:0];
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
    w_half = r_alu[1] ? r_rdata[31:16] : r_rdata[15:0];
  end

  always_comb begin
    w_load = r_rdata;
    case (r_loadtype)
      C_LT_LB:  w_load = {{24{w_byte[7]}}, w_byte};
      C_LT_LBU: w_load = {24'd0, w_byte};
      C_LT_LH:  w_load = {{16{w_half[15]}}, w_half};
      C_LT_LHU: w_load = {16'd0, w_half};
      default:  w_load = r_rdata;
    endcase
  end

  always_comb begin
    w_data = 32'd0;
    if (r_valid) begin
      w_data = r_memtoreg ? w_load : r_alu;
    end
  end

  assign valid_wb        = r_valid;
  assign RegWrite_wb     = r_valid & r_regwrite & (r_addr != 5'd0);
  assign RegWriteAddr_wb = r_addr;
  assign RegWriteData_wb = w_data;
  assign RetireCount     = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Self-checking bench for mem_wb_stage. A 32-bit and a 4-bit
//            counter instance share all inputs so counter wrap is visible.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall, flush, valid_mem, RegWrite_mem, MemToReg_mem;
  logic [2:0]  LoadType_mem;
  logic [4:0]  RegWriteAddr_mem;
  logic [31:0] AluResult_mem, MemReadData_mem;

  logic        valid_wb, RegWrite_wb, valid_wb4, RegWrite_wb4;
  logic [4:0]  RegWriteAddr_wb, RegWriteAddr_wb4;
  logic [31:0] RegWriteData_wb, RegWriteData_wb4;
  logic [31:0] RetireCount;
  logic [3:0]  RetireCount4;

  mem_wb_stage #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_mem(valid_mem), .RegWrite_mem(RegWrite_mem),
    .MemToReg_mem(MemToReg_mem), .LoadType_mem(LoadType_mem),
    .RegWriteAddr_mem(RegWriteAddr_mem), .AluResult_mem(AluResult_mem),
    .MemReadData_mem(MemReadData_mem),
    .valid_wb(valid_wb), .RegWrite_wb(RegWrite_wb),
    .RegWriteAddr_wb(RegWriteAddr_wb), .RegWriteData_wb(RegWriteData_wb),
    .RetireCount(RetireCount)
  );

  mem_wb_stage #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_mem(valid_mem), .RegWrite_mem(RegWrite_mem),
    .MemToReg_mem(MemToReg_mem), .LoadType_mem(LoadType_mem),
    .RegWriteAddr_mem(RegWriteAddr_mem), .AluResult_mem(AluResult_mem),
    .MemReadData_mem(MemReadData_mem),
    .valid_wb(valid_wb4), .RegWrite_wb(RegWrite_wb4),
    .RegWriteAddr_wb(RegWriteAddr_wb4), .RegWriteData_wb(RegWriteData_wb4),
    .RetireCount(RetireCount4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction currently held in WB, and the number
  // of instructions retired so far.
  typedef struct {
    logic        rw;
    logic        m2r;
    logic [2:0]  lt;
    logic [4:0]  addr;
    logic [31:0] alu;
    logic [31:0] rd;
  } inst_t;

  logic        m_valid;
  inst_t       m_inst;
  logic [31:0] m_cnt;

  function automatic logic [31:0] load_value(input logic [2:0] lt,
                                             input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] v;
    case (lt)
      3'd1, 3'd2: begin
        v = (w >> (8 * a[1:0])) & 32'hFF;
        if (lt == 3'd1 && v >= 32'd128) v = v - 32'd256;
      end
      3'd3, 3'd4: begin
        v = (w >> (16 * a[1])) & 32'hFFFF;
        if (lt == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_data();
    if (!m_valid) return 32'd0;
    return m_inst.m2r ? load_value(m_inst.lt, m_inst.alu, m_inst.rd) : m_inst.alu;
  endfunction

  function automatic logic exp_we();
    return m_valid && m_inst.rw && (m_inst.addr != 5'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("valid_wb",     {31'd0, valid_wb},    {31'd0, m_valid});
    chk("RegWrite_wb",  {31'd0, RegWrite_wb}, {31'd0, exp_we()});
    chk("RegWriteData", RegWriteData_wb,      exp_data());
    if (m_valid) chk("RegWriteAddr", {27'd0, RegWriteAddr_wb}, {27'd0, m_inst.addr});
    chk("RetireCount",  RetireCount,          m_cnt);
    chk("RetireCount4", {28'd0, RetireCount4}, {28'd0, m_cnt[3:0]});
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_inst  = '{rw: 1'b0, m2r: 1'b0, lt: 3'd0, addr: 5'd0, alu: 32'd0, rd: 32'd0};
    m_cnt   = 32'd0;
  endtask

  // One clock edge: advance the model from the current inputs, then check.
  task automatic cycle();
    logic  n_valid;
    inst_t n_inst;
    n_valid = m_valid;
    n_inst  = m_inst;
    if (flush) begin
      n_valid   = 1'b0;
      n_inst.rw = 1'b0;
    end else if (!stall) begin
      n_valid = valid_mem;
      n_inst  = '{rw: RegWrite_mem, m2r: MemToReg_mem, lt: LoadType_mem,
                  addr: RegWriteAddr_mem, alu: AluResult_mem, rd: MemReadData_mem};
    end
    if (m_valid && !stall) m_cnt = m_cnt + 32'd1;
    @(posedge clk);
    #1;
    m_valid = n_valid;
    m_inst  = n_inst;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [2:0] lt, input logic [4:0] a,
                       input logic [31:0] alu, input logic [31:0] rd);
    valid_mem        = v;
    RegWrite_mem     = rw;
    MemToReg_mem     = m2r;
    LoadType_mem     = lt;
    RegWriteAddr_mem = a;
    AluResult_mem    = alu;
    MemReadData_mem  = rd;
  endtask

  typedef struct {
    logic        v;
    logic        rw;
    logic        m2r;
    logic [2:0]  lt;
    logic [4:0]  addr;
    logic [31:0] alu;
    logic [31:0] rd;
    logic        e_we;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[14];

  logic [31:0] saved_data;
  logic [31:0] saved_cnt;

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 5'd5,  32'h1234_5678, 32'h0,         1'b1, 32'h1234_5678};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 3'd1, 5'd6,  32'h0000_1001, 32'h80FF_7F01, 1'b1, 32'h0000_007F};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 3'd1, 5'd7,  32'h0000_1003, 32'h80FF_7F01, 1'b1, 32'hFFFF_FF80};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 3'd2, 5'd8,  32'h0000_1003, 32'h80FF_7F01, 1'b1, 32'h0000_0080};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 3'd3, 5'd9,  32'h0000_1002, 32'h80FF_7F01, 1'b1, 32'hFFFF_80FF};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 3'd4, 5'd10, 32'h0000_1002, 32'h80FF_7F01, 1'b1, 32'h0000_80FF};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 3'd7, 5'd11, 32'h0000_1001, 32'h80FF_7F01, 1'b1, 32'h80FF_7F01};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'd0, 5'd0,  32'hDEAD_BEEF, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 3'd0, 5'd12, 32'h0000_1000, 32'h80FF_7F01, 1'b1, 32'h80FF_7F01};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 3'd3, 5'd13, 32'h0000_1003, 32'h80FF_7F01, 1'b1, 32'hFFFF_80FF};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 3'd1, 5'd14, 32'h0000_1000, 32'h80FF_7F01, 1'b1, 32'h0000_0001};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 3'd2, 5'd15, 32'h0000_1002, 32'h80FF_7F01, 1'b1, 32'h0000_00FF};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 3'd0, 5'd16, 32'h5555_AAAA, 32'h0,         1'b0, 32'h0000_0000};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 3'd0, 5'd17, 32'h0BAD_F00D, 32'h0,         1'b0, 32'h0BAD_F00D};

    // Power-on reset.
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // Directed vectors: one instruction per edge, back to back.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].lt, vecs[i].addr,
            vecs[i].alu, vecs[i].rd);
      cycle();
      chk("vec_we",   {31'd0, RegWrite_wb}, {31'd0, vecs[i].e_we});
      chk("vec_data", RegWriteData_wb,      vecs[i].e_data);
    end

    // Stall for three cycles while MEM presents new instructions.
    drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd9, 32'h0000_A5A5, 32'h0);
    cycle();
    saved_data = RegWriteData_wb;
    cycle();                                  // retires the held instruction once
    saved_cnt  = m_cnt;
    chk("pre_stall_data", saved_data, 32'h0000_A5A5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd0, 5'($urandom_range(1, 31)), $urandom, $urandom);
      cycle();
      chk("stall_data", RegWriteData_wb, 32'h0000_A5A5);
      chk("stall_cnt",  RetireCount,     saved_cnt);
    end

    // Flush together with stall inserts a bubble.
    flush = 1'b1;
    cycle();
    chk("fs_valid", {31'd0, valid_wb},    32'd0);
    chk("fs_we",    {31'd0, RegWrite_wb}, 32'd0);
    chk("fs_data",  RegWriteData_wb,      32'd0);
    chk("fs_cnt",   RetireCount,          saved_cnt);
    stall = 1'b0; flush = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            3'($urandom), 5'($urandom), $urandom, $urandom);
      stall = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle();
    end
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-run with a valid instruction in WB.
    drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd3, 32'h0000_0042, 32'h0);
    cycle();
    chk("pre_rst_valid", {31'd0, valid_wb}, 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_addr", {27'd0, RegWriteAddr_wb}, 32'd0);
    #2 rst = 1'b0;

    // 17 retirements on a 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd0, 5'(i + 1), 32'(i), 32'h0);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    cycle();
    chk("wrap_cnt4", {28'd0, RetireCount4}, 32'd1);
    chk("wrap_cnt32", RetireCount, 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
